counter: RTL and testbench

COUNTER -- requirements
Module: counter

---
 rtl/counter_pkg.sv | 15 +
 rtl/counter_tick.sv | 33 +++
 rtl/counter.sv | 78 +++++++
 tb/tb_counter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types and default configuration for the counter block.
// Optional feature macro used by the slice: COUNTER_SATURATE_EN.
package counter_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    localparam int CNT_WIDTH_DEF = 10;
    localparam int CNT_MAX_DEF   = 1023;
    localparam int CNT_DIV_DEF   = 1;
    localparam int CNT_STEP_DEF  = 1;

endpackage

// File: rtl/counter_tick.sv
// Prescaler: emits one tick on every DIV-th enabled cycle.
// Its phase is held while en is low. With DIV=1 the phase counter
// never leaves zero, so tick follows en directly.
module counter_tick
    import counter_pkg::*;
#(
    parameter int DIV = CNT_DIV_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    // Phase counter: advance on enabled cycles, restart after each tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/counter.sv
// Up/down modulo counter with a clock prescaler and a configurable step.
// Overflow wraps around MAX_COUNT by default; define COUNTER_SATURATE_EN
// at compile time to clamp at MAX_COUNT / 0 instead.
module counter
    import counter_pkg::*;
#(
    parameter int WIDTH     = CNT_WIDTH_DEF,
    parameter int MAX_COUNT = CNT_MAX_DEF,
    parameter int DIV       = CNT_DIV_DEF,
    parameter int STEP      = CNT_STEP_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             onoff,
    input  logic             pm,
    output logic [WIDTH-1:0] q
);

    // One extra bit of headroom so q+STEP can never alias past MAX_COUNT.
    localparam logic [WIDTH:0] MAX_X  = (WIDTH+1)'(MAX_COUNT);
    localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);

    logic tick;
    dir_e dir;

    assign dir = dir_e'(pm);

    counter_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (onoff),
        .tick  (tick)
    );

    function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] cur);
        logic [WIDTH:0] sum;
        logic [WIDTH:0] res;
        sum = {1'b0, cur} + STEP_X;
        if (sum <= MAX_X) begin
            res = sum;
        end else begin
`ifdef COUNTER_SATURATE_EN
            res = MAX_X;
`else
            res = sum - MAX_X - (WIDTH+1)'(1);
`endif
        end
        return res[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] step_down(input logic [WIDTH-1:0] cur);
        logic [WIDTH:0] ext;
        logic [WIDTH:0] res;
        ext = {1'b0, cur};
        if (ext >= STEP_X) begin
            res = ext - STEP_X;
        end else begin
`ifdef COUNTER_SATURATE_EN
            res = '0;
`else
            res = ext + MAX_X + (WIDTH+1)'(1) - STEP_X;
`endif
        end
        return res[WIDTH-1:0];
    endfunction

    // Count register: move one step in the sampled direction on each tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (tick) begin
            q <= (dir == DIR_UP) ? step_up(q) : step_down(q);
        end
    end

endmodule

// File: tb/tb_counter.sv
// Directed testbench for counter: default instance (DIV=1) and a DIV=4 instance.
module tb_counter;

    logic       clk = 1'b0;
    logic       reset, onoff, pm;
    logic [9:0] q;
    logic       reset4, onoff4, pm4;
    logic [9:0] q4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    counter u_dut (
        .clk   (clk),
        .reset (reset),
        .onoff (onoff),
        .pm    (pm),
        .q     (q)
    );

    counter #(.DIV(4)) u_div4 (
        .clk   (clk),
        .reset (reset4),
        .onoff (onoff4),
        .pm    (pm4),
        .q     (q4)
    );

    // Advance n rising edges, leaving time 1 unit past the last edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic restart;
        reset = 1'b0; onoff = 1'b0; pm = 1'b1;
        cyc(1);
        reset = 1'b1;
    endtask

    task automatic restart4;
        reset4 = 1'b0; onoff4 = 1'b0; pm4 = 1'b1;
        cyc(1);
        reset4 = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b0; onoff = 1'b1; pm = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            n_cmp++;
            if (q !== 10'd0) begin
                n_bad++;
                $display("FAIL reset_hold cyc=%0d q=%0d expected=0", i, q);
            end
        end
        reset = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            cyc(1);
            n_cmp++;
            if (q !== 10'(i)) begin
                n_bad++;
                $display("FAIL reset_release step=%0d q=%0d expected=%0d", i, q, i);
            end
        end
    endtask

    task automatic test_hold;
        restart();
        onoff = 1'b0; pm = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            n_cmp++;
            if (q !== 10'd0) begin
                n_bad++;
                $display("FAIL hold_zero cyc=%0d q=%0d expected=0", i, q);
            end
        end
        onoff = 1'b1;
        cyc(3);
        onoff = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            n_cmp++;
            if (q !== 10'd3) begin
                n_bad++;
                $display("FAIL hold_mid cyc=%0d q=%0d expected=3", i, q);
            end
        end
    endtask

    task automatic test_direction_change;
        logic [9:0] exp;
        restart();
        onoff = 1'b1; pm = 1'b1;
        cyc(4);
        pm = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            exp = 10'(3 - i);
            n_cmp++;
            if (q !== exp) begin
                n_bad++;
                $display("FAIL dir_change i=%0d q=%0d expected=%0d", i, q, exp);
            end
        end
    endtask

    task automatic test_underflow;
        logic [9:0] exp [6];
        exp[0] = 10'd4; exp[1] = 10'd3; exp[2] = 10'd2;
        exp[3] = 10'd1; exp[4] = 10'd0;
`ifdef COUNTER_SATURATE_EN
        exp[5] = 10'd0;
`else
        exp[5] = 10'd1023;
`endif
        restart();
        onoff = 1'b1; pm = 1'b1;
        cyc(5);
        n_cmp++;
        if (q !== 10'd5) begin
            n_bad++;
            $display("FAIL underflow_setup q=%0d expected=5", q);
        end
        pm = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            n_cmp++;
            if (q !== exp[i]) begin
                n_bad++;
                $display("FAIL underflow i=%0d q=%0d expected=%0d", i, q, exp[i]);
            end
        end
    endtask

    task automatic test_overflow;
        logic [9:0] exp [3];
        exp[0] = 10'd1023;
`ifdef COUNTER_SATURATE_EN
        exp[1] = 10'd1023; exp[2] = 10'd1023;
`else
        exp[1] = 10'd0; exp[2] = 10'd1;
`endif
        restart();
        onoff = 1'b1; pm = 1'b1;
        cyc(1022);
        n_cmp++;
        if (q !== 10'd1022) begin
            n_bad++;
            $display("FAIL overflow_setup q=%0d expected=1022", q);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            n_cmp++;
            if (q !== exp[i]) begin
                n_bad++;
                $display("FAIL overflow i=%0d q=%0d expected=%0d", i, q, exp[i]);
            end
        end
    endtask

    task automatic test_async_reset;
        restart();
        onoff = 1'b1; pm = 1'b1;
        cyc(37);
        n_cmp++;
        if (q !== 10'd37) begin
            n_bad++;
            $display("FAIL async_setup q=%0d expected=37", q);
        end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (q !== 10'd0) begin
            n_bad++;
            $display("FAIL async_reset q=%0d expected=0", q);
        end
        cyc(1);
        reset = 1'b1;
    endtask

    task automatic test_prescaler;
        logic [9:0] exp;
        restart4();
        onoff4 = 1'b1; pm4 = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            cyc(1);
            exp = 10'(i / 4);
            n_cmp++;
            if (q4 !== exp) begin
                n_bad++;
                $display("FAIL div4_run edge=%0d q=%0d expected=%0d", i, q4, exp);
            end
        end
        // Pause mid-phase: 6 enabled edges leave q=1 with two edges to the next tick.
        restart4();
        onoff4 = 1'b1;
        cyc(6);
        onoff4 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            n_cmp++;
            if (q4 !== 10'd1) begin
                n_bad++;
                $display("FAIL div4_pause cyc=%0d q=%0d expected=1", i, q4);
            end
        end
        onoff4 = 1'b1;
        cyc(1);
        n_cmp++;
        if (q4 !== 10'd1) begin
            n_bad++;
            $display("FAIL div4_resume1 q=%0d expected=1", q4);
        end
        cyc(1);
        n_cmp++;
        if (q4 !== 10'd2) begin
            n_bad++;
            $display("FAIL div4_resume2 q=%0d expected=2", q4);
        end
        // Reset after 3 enabled edges must drop the partial phase.
        restart4();
        onoff4 = 1'b1;
        cyc(3);
        #2;
        reset4 = 1'b0;
        cyc(1);
        reset4 = 1'b1;
        cyc(3);
        n_cmp++;
        if (q4 !== 10'd0) begin
            n_bad++;
            $display("FAIL div4_phase_clear q=%0d expected=0", q4);
        end
        cyc(1);
        n_cmp++;
        if (q4 !== 10'd1) begin
            n_bad++;
            $display("FAIL div4_phase_tick q=%0d expected=1", q4);
        end
    endtask

    initial begin
        reset = 1'b0; onoff = 1'b0; pm = 1'b1;
        reset4 = 1'b0; onoff4 = 1'b0; pm4 = 1'b1;
        #1;
        test_reset();
        test_hold();
        test_direction_change();
        test_underflow();
        test_overflow();
        test_async_reset();
        test_prescaler();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
